// File: rtl/input_buffer_arbiter.sv
// Round-robin arbiter with frame lock feeding one inputBuffer enqueue port, with credit flow control.
// Optional stall counter output enabled by defining ARB_STALL_CNT_EN.
module input_buffer_arbiter #(
  parameter int unsigned        N                  = 8,
  parameter int unsigned        DATA_WIDTH         = 32,
  parameter int unsigned        NUM_SRC            = 4,
  parameter int unsigned        IB_DEPTH           = 4,
  parameter logic [NUM_SRC-1:0] INITIAL_MASK       = {{(NUM_SRC-1){1'b0}}, 1'b1},
  parameter logic [7:0]         PERSONAL_CONFIG_ID = 8'd0,
  localparam int unsigned       IDW                = $clog2(NUM_SRC),
  localparam int unsigned       CW                 = $clog2(IB_DEPTH) + 1
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          tracing,
  input  logic [7:0]                                    configId,
  input  logic [7:0]                                    configData,
  input  logic [NUM_SRC-1:0]                            src_valid,
  input  logic [NUM_SRC-1:0][1:0]                       src_eof,
  input  logic [NUM_SRC-1:0][N-1:0][DATA_WIDTH-1:0]     src_vector,
  output logic [NUM_SRC-1:0]                            src_ready,
  input  logic                                          ib_dequeue,
  output logic                                          enqueue,
  output logic [1:0]                                    eof_out,
  output logic [N-1:0][DATA_WIDTH-1:0]                  vector_out,
  output logic [IDW-1:0]                                src_id_out,
  output logic [CW-1:0]                                 credits,
  output logic                                          credit_err
`ifdef ARB_STALL_CNT_EN
  ,
  output logic [15:0]                                   stall_cnt
`endif
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state, state_nxt;
  logic [IDW-1:0]     rr_ptr, rr_nxt;
  logic [IDW-1:0]     lock_id, lock_nxt;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] req;
  logic [IDW-1:0]     grant_id;
  logic               grant_any;
  logic               xfer;
  logic               cfg_write;
  int unsigned        scan_idx;

  localparam logic [CW-1:0] CRED_MAX = CW'(IB_DEPTH - 1);

  assign req       = src_valid & mask;
  assign cfg_write = !tracing && (configId == PERSONAL_CONFIG_ID);

  generate
    if (NUM_SRC < 8) begin : g_cfg_unused
      logic unused_cfg_bits;
      assign unused_cfg_bits = ^configData[7:NUM_SRC];
    end
  endgenerate

  always_comb begin
    grant_id  = lock_id;
    grant_any = 1'b0;
    scan_idx  = 0;
    src_ready = '0;
    xfer      = 1'b0;
    state_nxt = state;
    rr_nxt    = rr_ptr;
    lock_nxt  = lock_id;

    if (state == LOCKED) begin
      grant_any = 1'b1;
    end else begin
      // Scan starts one past the last frame's winner so it gets lowest priority
      for (int unsigned k = 1; k <= NUM_SRC; k++) begin
        scan_idx = (32'(rr_ptr) + k) % NUM_SRC;
        if (!grant_any && req[IDW'(scan_idx)]) begin
          grant_any = 1'b1;
          grant_id  = IDW'(scan_idx);
        end
      end
    end

    if (tracing && grant_any && mask[grant_id] && (credits != '0))
      src_ready[grant_id] = 1'b1;
    xfer = |(src_valid & src_ready);

    if (!tracing) begin
      state_nxt = IDLE;
    end else if (xfer) begin
      if (src_eof[grant_id] != 2'b00) begin
        state_nxt = IDLE;
        rr_nxt    = grant_id;
      end else begin
        state_nxt = LOCKED;
        lock_nxt  = grant_id;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      lock_id <= '0;
    end else begin
      state   <= state_nxt;
      rr_ptr  <= rr_nxt;
      lock_id <= lock_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask <= INITIAL_MASK;
    end else if (cfg_write) begin
      mask <= configData[NUM_SRC-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enqueue    <= 1'b0;
      eof_out    <= '0;
      vector_out <= '0;
      src_id_out <= '0;
    end else begin
      enqueue <= xfer;
      if (xfer) begin
        eof_out    <= src_eof[grant_id];
        vector_out <= src_vector[grant_id];
        src_id_out <= grant_id;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits    <= CRED_MAX;
      credit_err <= 1'b0;
    end else begin
      case ({xfer, ib_dequeue})
        2'b10: credits <= credits - 1'b1;
        2'b01: begin
          if (credits == CRED_MAX) credit_err <= 1'b1;
          else                     credits    <= credits + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef ARB_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (cfg_write) begin
      stall_cnt <= '0;
    end else if (tracing && (|req) && (credits == '0) && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_input_buffer_arbiter.sv
// Randomized and directed bench for input_buffer_arbiter checked against an in-bench reference model.
// Stall counter checks are included when ARB_STALL_CNT_EN is defined.
module tb_input_buffer_arbiter;
  localparam int NS  = 4;
  localparam int NN  = 8;
  localparam int DW  = 32;
  localparam int DEP = 4;

  logic                         clk = 1'b0;
  logic                         rst_n = 1'b0;
  logic                         tracing = 1'b1;
  logic [7:0]                   configId = 8'h5A;
  logic [7:0]                   configData = 8'h00;
  logic [NS-1:0]                src_valid = '0;
  logic [NS-1:0][1:0]           src_eof = '0;
  logic [NS-1:0][NN-1:0][DW-1:0] src_vector = '0;
  logic [NS-1:0]                src_ready;
  logic                         ib_dequeue = 1'b0;
  logic                         enqueue;
  logic [1:0]                   eof_out;
  logic [NN-1:0][DW-1:0]        vector_out;
  logic [1:0]                   src_id_out;
  logic [2:0]                   credits;
  logic                         credit_err;
`ifdef ARB_STALL_CNT_EN
  logic [15:0]                  stall_cnt;
`endif

  input_buffer_arbiter #(
    .N(NN), .DATA_WIDTH(DW), .NUM_SRC(NS), .IB_DEPTH(DEP),
    .INITIAL_MASK(4'b0001), .PERSONAL_CONFIG_ID(8'h00)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tracing(tracing), .configId(configId),
    .configData(configData), .src_valid(src_valid), .src_eof(src_eof),
    .src_vector(src_vector), .src_ready(src_ready), .ib_dequeue(ib_dequeue),
    .enqueue(enqueue), .eof_out(eof_out), .vector_out(vector_out),
    .src_id_out(src_id_out), .credits(credits), .credit_err(credit_err)
`ifdef ARB_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model state, in plain integers
  bit            m_locked;
  int            m_lock, m_rr, m_cred, m_stall;
  bit            m_err;
  logic [NS-1:0] m_mask;
  bit            x_enq;
  logic [1:0]    x_eof;
  logic [NN-1:0][DW-1:0] x_vec;
  int            x_id;

  task automatic model_reset();
    m_locked = 0; m_lock = 0; m_rr = 0; m_cred = DEP - 1; m_stall = 0;
    m_err = 0; m_mask = 4'b0001; x_enq = 0; x_eof = 0; x_vec = '0; x_id = 0;
  endtask

  always @(negedge clk) begin
    logic [NS-1:0] r;
    int j;
    if (!rst_n) begin
      model_reset();
    end else begin
      chk("enqueue", enqueue, x_enq);
      if (x_enq) begin
        chk("src_id_out", src_id_out, x_id);
        chk("eof_out", eof_out, x_eof);
        chk("vector_out", vector_out, x_vec);
      end
      chk("credits", credits, m_cred);
      chk("credit_err", credit_err, m_err);
`ifdef ARB_STALL_CNT_EN
      chk("stall_cnt", stall_cnt, m_stall);
`endif
      r = '0;
      if (tracing && m_cred > 0) begin
        if (m_locked) begin
          if (m_mask[m_lock]) r[m_lock] = 1'b1;
        end else begin
          for (int k = 1; k <= NS; k++) begin
            int c;
            c = (m_rr + k) % NS;
            if (src_valid[c] && m_mask[c]) begin r[c] = 1'b1; break; end
          end
        end
      end
      chk("src_ready", src_ready, r);

      j = -1;
      for (int s = 0; s < NS; s++) if (src_valid[s] && r[s]) j = s;
      x_enq = (j >= 0);
      if (j >= 0) begin x_id = j; x_eof = src_eof[j]; x_vec = src_vector[j]; end

      if (tracing && (|(src_valid & m_mask)) && m_cred == 0 && m_stall < 65535) m_stall++;
      if (!tracing && configId == 8'h00) begin m_mask = configData[NS-1:0]; m_stall = 0; end

      if (j >= 0 && !ib_dequeue) m_cred--;
      else if (j < 0 && ib_dequeue) begin
        if (m_cred == DEP - 1) m_err = 1;
        else m_cred++;
      end

      if (!tracing) m_locked = 0;
      else if (j >= 0) begin
        if (src_eof[j] != 2'b00) begin m_locked = 0; m_rr = j; end
        else begin m_locked = 1; m_lock = j; end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
    for (int s = 0; s < NS; s++)
      for (int l = 0; l < NN; l++) src_vector[s][l] = $urandom();
  endtask

  task automatic cfg(input logic [7:0] d);
    tracing = 1'b0; configId = 8'h00; configData = d;
    src_valid = '0; ib_dequeue = 1'b0;
    cyc();
    tracing = 1'b1; configId = 8'h5A;
  endtask

  int cnt;

  initial begin
    model_reset();
    cyc(); cyc();
    rst_n = 1'b1;
    chk("reset_enqueue", enqueue, 0);
    chk("reset_credits", credits, 3);
    chk("reset_credit_err", credit_err, 0);
    chk("reset_src_id", src_id_out, 0);

    // Round robin across all four sources, single-vector frames
    cfg(8'h0F);
    src_valid = 4'b1111; src_eof = {4{2'b01}}; ib_dequeue = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("t1_enqueue", enqueue, 1);
      chk("t1_src_id", src_id_out, (i + 1) % 4);
    end
    src_valid = '0; ib_dequeue = 1'b0; cyc();

    // Frame lock: src0 sends 3 vectors, src1 waits
    src_valid = 4'b0001; src_eof = {2'b01, 2'b01, 2'b01, 2'b00}; ib_dequeue = 1'b1;
    cyc(); chk("t2_id0", src_id_out, 0);
    src_valid = 4'b0011; #1; chk("t2_src1_blocked", src_ready[1], 0);
    cyc(); chk("t2_id1", src_id_out, 0);
    src_eof[0] = 2'b01;
    cyc(); chk("t2_id2", src_id_out, 0);
    src_valid = 4'b0010;
    cyc(); chk("t2_id3", src_id_out, 1); chk("t2_enq3", enqueue, 1);
    src_valid = '0; ib_dequeue = 1'b0; cyc();

    // Credit exhaustion then one slot returned
    src_valid = 4'b0001; src_eof[0] = 2'b10; cnt = 0;
    for (int i = 0; i < 6; i++) begin cyc(); cnt += int'(enqueue); end
    chk("t3_enq_count", cnt, 3);
    chk("t3_credits_zero", credits, 0);
    chk("t3_ready_zero", src_ready, 0);
    ib_dequeue = 1'b1; cyc(); ib_dequeue = 1'b0; cnt = 0;
    for (int i = 0; i < 4; i++) begin cyc(); cnt += int'(enqueue); end
    chk("t3_one_more", cnt, 1);

    // Simultaneous transfer and dequeue, then overflowing dequeue
    src_valid = '0; ib_dequeue = 1'b1; cyc(); cyc();
    chk("t4_credits2", credits, 2);
    src_valid = 4'b0001; cyc();
    chk("t4_credits_hold", credits, 2); chk("t4_enq", enqueue, 1);
    src_valid = '0; cyc();
    chk("t4_credits3", credits, 3); chk("t4_err0", credit_err, 0);
    cyc();
    chk("t4_err1", credit_err, 1); chk("t4_credits_sat", credits, 3);
    ib_dequeue = 1'b0;

    // Mask reconfiguration and tracing drop mid-frame
    cfg(8'h04);
    src_valid = 4'b1111; src_eof = {4{2'b11}}; ib_dequeue = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(); chk("t5_enq", enqueue, 1); chk("t5_only_src2", src_id_out, 2);
    end
    src_valid = '0; ib_dequeue = 1'b0; cyc();
    cfg(8'h05);
    src_valid = 4'b0001; src_eof[0] = 2'b00; ib_dequeue = 1'b1;
    cyc(); chk("t5_lock_src0", src_id_out, 0);
    tracing = 1'b0; src_valid = '0; ib_dequeue = 1'b0;
    cyc(); chk("t5_no_enq_off", enqueue, 0);
    tracing = 1'b1; src_valid = 4'b0100; src_eof[2] = 2'b01;
    cyc(); chk("t5_unlocked", enqueue, 1); chk("t5_resume_src2", src_id_out, 2);

`ifdef ARB_STALL_CNT_EN
    src_valid = 4'b0100; ib_dequeue = 1'b0;
    for (int i = 0; i < 8 && credits != 0; i++) cyc();
    chk("t6_drained", credits, 0);
    cfg(8'h04);
    src_valid = 4'b0100;
    for (int i = 0; i < 5; i++) cyc();
    chk("t6_stall5", stall_cnt, 5);
    cfg(8'h04);
    chk("t6_stall_clr", stall_cnt, 0);
`endif

    // Asynchronous reset in the middle of a frame
    src_valid = '0; ib_dequeue = 1'b1; cyc();
    src_valid = 4'b0100; src_eof[2] = 2'b00; ib_dequeue = 1'b0;
    cyc(); chk("t6_pre_reset_enq", enqueue, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_enqueue", enqueue, 0);
    chk("t6_rst_eof", eof_out, 0);
    chk("t6_rst_vector", vector_out, 0);
    chk("t6_rst_src_id", src_id_out, 0);
    chk("t6_rst_credits", credits, 3);
    chk("t6_rst_err", credit_err, 0);
    cyc(); rst_n = 1'b1;
    src_valid = 4'b0001; src_eof[0] = 2'b01;
    cyc(); chk("t6_after_rst_src0", src_id_out, 0); chk("t6_after_rst_enq", enqueue, 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      tracing    = ($urandom_range(0, 9) != 0);
      configId   = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'h33;
      configData = 8'($urandom());
      src_valid  = 4'($urandom());
      for (int s = 0; s < NS; s++)
        src_eof[s] = ($urandom_range(0, 1) != 0) ? 2'b00 : 2'($urandom_range(1, 3));
      ib_dequeue = ($urandom_range(0, 1) != 0);
      cyc();
    end
    tracing = 1'b1; src_valid = '0; ib_dequeue = 1'b0;
    cyc(); cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
